// File: rtl/fg_cfg_pkg.sv
// Shared definitions for the configuration register bank: default reset
// image, commit-address helper and the commit FSM state encoding.
package fg_cfg_pkg;

    // Register 0 lives in the most significant byte.
    localparam logic [55:0] FG_CFG_RESET_VALUES = 56'h49050000003200;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } fg_state_e;

    // The all-ones address is reserved as the commit command.
    function automatic int unsigned commit_addr(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/fg_edge_sync.sv
// Multi-stage synchroniser for an active-low asynchronous input with a
// falling-edge detector on the synchronised output. All flops reset to 1 so
// that releasing reset never looks like an asserted strobe.
module fg_edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the pin through the synchroniser chain and remember the last output.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = async_i;
        for (int i = 1; i < int'(STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];
    end

    // Synchroniser and edge-history registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign fall_o = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/fg_config_regbank.sv
// Double-buffered configuration register bank for the frequency generator.
// Writes arrive over an asynchronous strobe interface into a shadow bank; a
// write to the all-ones address commits the shadow bank, which is copied into
// the active bank when the generator is stopped or at a period boundary.
// Optional readback of the shadow bank: define FG_CFG_READBACK_EN.
//
// state   | meaning
// IDLE    | no commit outstanding
// PENDING | commit received, waiting for run_i=0 or boundary_i=1
module fg_config_regbank
    import fg_cfg_pkg::*;
#(
    parameter int unsigned                NUM_REGS     = 7,
    parameter int unsigned                DATA_W       = 8,
    parameter int unsigned                ADDR_W       = 3,
    parameter int unsigned                SYNC_STAGES  = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUES = FG_CFG_RESET_VALUES
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic                       wr_n_i,
    input  logic                       cs_n_i,
    input  logic                       run_i,
    input  logic                       boundary_i,
    output logic [NUM_REGS*DATA_W-1:0] cfg_bus_o,
    output logic                       pending_o,
    output logic                       cfg_update_o,
    output logic                       err_o
`ifdef FG_CFG_READBACK_EN
    ,
    output logic [DATA_W-1:0]          rd_data_o
`endif
);

    localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] COMMIT_A   = ADDR_W'(commit_addr(ADDR_W));

    logic wr_sync, wr_fall, cs_sync, cs_fall, cs_active, wr_evt;

    fg_edge_sync #(.STAGES(SYNC_STAGES + 1)) u_wr_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(wr_n_i),
        .sync_o (wr_sync),
        .fall_o (wr_fall)
    );

    fg_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(cs_n_i),
        .sync_o (cs_sync),
        .fall_o (cs_fall)
    );

    // Select is active from its synchronised falling edge onward.
    assign cs_active = ~cs_sync | cs_fall;
    assign wr_evt    = wr_fall & cs_active;

    fg_state_e         state_q, state_d;
    logic              evt_q, evt_d;
    logic [ADDR_W-1:0] evt_addr_q, evt_addr_d;
    logic [DATA_W-1:0] evt_data_q, evt_data_d;
    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] shadow_d [NUM_REGS];
    logic [DATA_W-1:0] active_q [NUM_REGS];
    logic [DATA_W-1:0] active_d [NUM_REGS];
    logic              update_q, update_d;
    logic              err_q, err_d;
    logic              do_write, do_commit, do_err;

    // Decode the registered write event, update shadow bank and run the commit FSM.
    always_comb begin
        evt_d      = wr_evt;
        evt_addr_d = wr_evt ? addr_i : evt_addr_q;
        evt_data_d = wr_evt ? data_i : evt_data_q;

        do_write  = evt_q && (evt_addr_q < NUM_REGS_A);
        do_commit = evt_q && (evt_addr_q == COMMIT_A);
        do_err    = evt_q && !do_write && !do_commit;

        shadow_d = shadow_q;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (do_write && evt_addr_q == ADDR_W'(i)) begin
                shadow_d[i] = evt_data_q;
            end
        end

        active_d = active_q;
        state_d  = state_q;
        update_d = 1'b0;
        err_d    = err_q | do_err;

        case (state_q)
            IDLE: begin
                if (do_commit) state_d = PENDING;
            end
            PENDING: begin
                // Copy uses the pre-write shadow; a concurrent write waits for the next commit.
                if (!run_i || boundary_i) begin
                    active_d = shadow_q;
                    update_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, event capture and both register banks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            evt_q      <= 1'b0;
            evt_addr_q <= '0;
            evt_data_q <= '0;
            update_q   <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                shadow_q[i] <= RESET_VALUES[(int'(NUM_REGS) - 1 - i) * int'(DATA_W) +: DATA_W];
                active_q[i] <= RESET_VALUES[(int'(NUM_REGS) - 1 - i) * int'(DATA_W) +: DATA_W];
            end
        end else begin
            state_q    <= state_d;
            evt_q      <= evt_d;
            evt_addr_q <= evt_addr_d;
            evt_data_q <= evt_data_d;
            update_q   <= update_d;
            err_q      <= err_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

    // Flatten the active bank, register 0 in the MSBs.
    always_comb begin
        cfg_bus_o = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            cfg_bus_o[(int'(NUM_REGS) - 1 - i) * int'(DATA_W) +: DATA_W] = active_q[i];
        end
    end

    assign pending_o    = (state_q == PENDING);
    assign cfg_update_o = update_q;
    assign err_o        = err_q;

`ifdef FG_CFG_READBACK_EN
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Latch the read address on select assertion and register the shadow value.
    always_comb begin
        rd_addr_d = cs_fall ? addr_i : rd_addr_q;
        rd_data_d = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (rd_addr_q == ADDR_W'(i)) rd_data_d = shadow_q[i];
        end
    end

    // Readback address and data registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
`endif

endmodule

// File: tb/tb_fg_config_regbank.sv
// Self-checking bench for fg_config_regbank. Two instances share stimulus:
// dut_a uses the default 7-register build, dut_b has 6 registers so that
// address 6 is invalid. Expected active-bank images are queued at commit time
// and compared when cfg_update_o pulses.
module tb_fg_config_regbank;

    localparam logic [55:0] RST_A = 56'h49050000003200;
    localparam logic [47:0] RST_B = 48'h490500000032;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  data_i = '0;
    logic [2:0]  addr_i = '0;
    logic        wr_n_i = 1'b1;
    logic        cs_n_i = 1'b1;
    logic        run_i = 1'b0;
    logic        boundary_i = 1'b0;

    logic [55:0] bus_a;
    logic [47:0] bus_b;
    logic        pend_a, pend_b, upd_a, upd_b, err_a, err_b;
`ifdef FG_CFG_READBACK_EN
    logic [7:0]  rd_a, rd_b;
`endif

    always #5 clk_i = ~clk_i;

    fg_config_regbank #(
        .NUM_REGS(7), .DATA_W(8), .ADDR_W(3), .SYNC_STAGES(2), .RESET_VALUES(RST_A)
    ) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .addr_i(addr_i),
        .wr_n_i(wr_n_i), .cs_n_i(cs_n_i), .run_i(run_i), .boundary_i(boundary_i),
        .cfg_bus_o(bus_a), .pending_o(pend_a), .cfg_update_o(upd_a), .err_o(err_a)
`ifdef FG_CFG_READBACK_EN
        , .rd_data_o(rd_a)
`endif
    );

    fg_config_regbank #(
        .NUM_REGS(6), .DATA_W(8), .ADDR_W(3), .SYNC_STAGES(2), .RESET_VALUES(RST_B)
    ) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .addr_i(addr_i),
        .wr_n_i(wr_n_i), .cs_n_i(cs_n_i), .run_i(run_i), .boundary_i(boundary_i),
        .cfg_bus_o(bus_b), .pending_o(pend_b), .cfg_update_o(upd_b), .err_o(err_b)
`ifdef FG_CFG_READBACK_EN
        , .rd_data_o(rd_b)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [7:0]  sh_a [7];
    logic [7:0]  sh_b [6];
    logic [55:0] act_a;
    logic [47:0] act_b;
    bit          pend_m;
    logic [55:0] q_a [$];
    logic [47:0] q_b [$];
    int          upd_cnt_a = 0;
    int          upd_cnt_b = 0;

    function automatic logic [55:0] pack_a();
        logic [55:0] v;
        for (int i = 0; i < 7; i++) v[(6-i)*8 +: 8] = sh_a[i];
        return v;
    endfunction

    function automatic logic [47:0] pack_b();
        logic [47:0] v;
        for (int i = 0; i < 6; i++) v[(5-i)*8 +: 8] = sh_b[i];
        return v;
    endfunction

    task automatic model_reset();
        logic [55:0] ra;
        logic [47:0] rb;
        ra = RST_A;
        rb = RST_B;
        for (int i = 0; i < 7; i++) sh_a[i] = ra[(6-i)*8 +: 8];
        for (int i = 0; i < 6; i++) sh_b[i] = rb[(5-i)*8 +: 8];
        act_a  = RST_A;
        act_b  = RST_B;
        pend_m = 1'b0;
        q_a.delete();
        q_b.delete();
    endtask

    task automatic model_write(input logic [2:0] a, input logic [7:0] d);
        if (a < 3'd7) sh_a[a] = d;
        if (a < 3'd6) sh_b[a] = d;
    endtask

    task automatic model_apply();
        act_a = pack_a();
        act_b = pack_b();
        q_a.push_back(act_a);
        q_b.push_back(act_b);
        pend_m = 1'b0;
    endtask

    task automatic model_commit();
        if (!pend_m) begin
            if (!run_i) model_apply();
            else        pend_m = 1'b1;
        end
    endtask

    // Scoreboard: every update pulse must match a queued image.
    always @(negedge clk_i) begin
        if (!rst_i && upd_a) begin
            upd_cnt_a++;
            if (q_a.size() == 0) check_eq("upd_a_unexpected", 64'(upd_a), 64'd0);
            else                 check_eq("upd_a_bus", 64'(bus_a), 64'(q_a.pop_front()));
        end
        if (!rst_i && upd_b) begin
            upd_cnt_b++;
            if (q_b.size() == 0) check_eq("upd_b_unexpected", 64'(upd_b), 64'd0);
            else                 check_eq("upd_b_bus", 64'(bus_b), 64'(q_b.pop_front()));
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d, input int hold);
        @(negedge clk_i);
        addr_i = a; data_i = d; cs_n_i = 1'b0; wr_n_i = 1'b0;
        repeat (hold) @(negedge clk_i);
        wr_n_i = 1'b1; cs_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
        model_write(a, d);
        bus_write(a, d, 8);
    endtask

    task automatic commit();
        model_commit();
        bus_write(3'd7, 8'hFF, 8);
    endtask

    task automatic pulse_boundary();
        if (pend_m) model_apply();
        @(negedge clk_i);
        boundary_i = 1'b1;
        @(negedge clk_i);
        boundary_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    int cnt0;

    initial begin
        model_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);

        // Reset state
        check_eq("rst_bus_a", 64'(bus_a), 64'(RST_A));
        check_eq("rst_bus_b", 64'(bus_b), 64'(RST_B));
        check_eq("rst_pend",  64'({pend_a, pend_b}), 64'd0);
        check_eq("rst_err",   64'({err_a, err_b}), 64'd0);
        check_eq("rst_upd_cnt", 64'(upd_cnt_a), 64'd0);

        // Stopped generator: write is shadow-only until commit, then one update
        run_i = 1'b0;
        reg_write(3'd1, 8'hA5);
        check_eq("wr_no_apply", 64'(bus_a), 64'(act_a));
        cnt0 = upd_cnt_a;
        commit();
        check_eq("commit_bus", 64'(bus_a), 64'h49A50000003200);
        check_eq("commit_pulses", 64'(upd_cnt_a - cnt0), 64'd1);

        // Running generator: commit waits for boundary; also check commit latency
        run_i = 1'b1;
        reg_write(3'd5, 8'h10);
        model_commit();
        @(negedge clk_i);
        addr_i = 3'd7; data_i = 8'h00; cs_n_i = 1'b0; wr_n_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1 check_eq("lat_pend_early", 64'(pend_a), 64'd0);
        @(posedge clk_i);
        #1 check_eq("lat_pend_on", 64'(pend_a), 64'd1);
        repeat (4) @(negedge clk_i);
        wr_n_i = 1'b1; cs_n_i = 1'b1;
        repeat (10) @(negedge clk_i);
        check_eq("run_pend", 64'(pend_a), 64'd1);
        check_eq("run_bus_hold", 64'(bus_a), 64'h49A50000003200);
        cnt0 = upd_cnt_a;
        model_apply();
        boundary_i = 1'b1;
        check_eq("bnd_upd_same_cycle", 64'(upd_a), 64'd0);
        @(posedge clk_i);
        #1;
        check_eq("bnd_upd_next", 64'(upd_a), 64'd1);
        check_eq("bnd_pend_clr", 64'(pend_a), 64'd0);
        check_eq("bnd_bus", 64'(bus_a), 64'h49A50000001000);
        @(negedge clk_i);
        boundary_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("bnd_pulses", 64'(upd_cnt_a - cnt0), 64'd1);

        // Held-low strobe gives one write; data changed mid-strobe must not land
        model_write(3'd2, 8'h33);
        @(negedge clk_i);
        addr_i = 3'd2; data_i = 8'h33; cs_n_i = 1'b0; wr_n_i = 1'b0;
        repeat (10) @(negedge clk_i);
        data_i = 8'h44;
        repeat (10) @(negedge clk_i);
        wr_n_i = 1'b1; cs_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
        cnt0 = upd_cnt_a;
        commit();
        commit();
        check_eq("dbl_commit_pend", 64'(pend_a), 64'd1);
        pulse_boundary();
        repeat (4) @(negedge clk_i);
        check_eq("held_bus", 64'(bus_a), 64'h49A53300001000);
        check_eq("dbl_commit_pulses", 64'(upd_cnt_a - cnt0), 64'd1);

        // Invalid address on the 6-register instance
        run_i = 1'b0;
        reg_write(3'd6, 8'h77);
        check_eq("err_b_set", 64'(err_b), 64'd1);
        check_eq("err_a_clear", 64'(err_a), 64'd0);
        commit();
        check_eq("err_b_bus", 64'(bus_b), 64'(act_b));
        check_eq("err_a_bus", 64'(bus_a), 64'h49A53300001077);
        repeat (20) @(negedge clk_i);
        check_eq("err_b_sticky", 64'(err_b), 64'd1);

        // Reset while pending drops the commit
        run_i = 1'b1;
        reg_write(3'd0, 8'hEE);
        commit();
        check_eq("prerst_pend", 64'(pend_a), 64'd1);
        cnt0 = upd_cnt_a;
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        run_i = 1'b0;
        repeat (12) @(negedge clk_i);
        check_eq("rst_pend_bus_a", 64'(bus_a), 64'(RST_A));
        check_eq("rst_pend_bus_b", 64'(bus_b), 64'(RST_B));
        check_eq("rst_pend_clr", 64'({pend_a, pend_b}), 64'd0);
        check_eq("rst_err_clr", 64'(err_b), 64'd0);
        check_eq("rst_no_update", 64'(upd_cnt_a - cnt0), 64'd0);

`ifdef FG_CFG_READBACK_EN
        reg_write(3'd1, 8'h5A);
        @(negedge clk_i);
        addr_i = 3'd1; cs_n_i = 1'b0;
        repeat (6) @(negedge clk_i);
        check_eq("rd_a_addr1", 64'(rd_a), 64'(sh_a[1]));
        check_eq("rd_b_addr1", 64'(rd_b), 64'h5A);
        cs_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
        addr_i = 3'd6; cs_n_i = 1'b0;
        repeat (6) @(negedge clk_i);
        check_eq("rd_a_addr6", 64'(rd_a), 64'(sh_a[6]));
        check_eq("rd_b_invalid", 64'(rd_b), 64'd0);
        cs_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
`endif

        check_eq("q_a_drained", 64'(q_a.size()), 64'd0);
        check_eq("q_b_drained", 64'(q_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fg_config_regbank.md
FG_CONFIG_REGBANK -- requirements
Module: fg_config_regbank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 7: number of configuration registers, range 1..(2^ADDR_W - 1).
REQ-002 SHALL have parameter DATA_W, default 8: width of each register.
REQ-003 SHALL have parameter ADDR_W, default 3: width of the address bus.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for cs_n_i; wr_n_i uses SYNC_STAGES+1.
REQ-005 SHALL have parameter RESET_VALUES, width NUM_REGS*DATA_W, default 56'h49050000003200, with register 0 in the MSBs.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port data_i, input, DATA_W bits: asynchronous write data, held stable around the strobe.
REQ-009 SHALL have port addr_i, input, ADDR_W bits: asynchronous register address, held stable around the strobe.
REQ-010 SHALL have port wr_n_i, input, 1 bit: asynchronous write strobe, active-low.
REQ-011 SHALL have port cs_n_i, input, 1 bit: asynchronous chip select, active-low.
REQ-012 SHALL have port run_i, input, 1 bit: the generator is running.
REQ-013 SHALL have port boundary_i, input, 1 bit: one-cycle pulse at the end of a generator period.
REQ-014 SHALL have port cfg_bus_o, output, NUM_REGS*DATA_W bits: active configuration, with register 0 in the MSBs.
REQ-015 SHALL have port pending_o, output, 1 bit: a commit is waiting to be applied.
REQ-016 SHALL have port cfg_update_o, output, 1 bit: one-cycle pulse after the active bank is loaded.
REQ-017 SHALL have port err_o, output, 1 bit: sticky flag for a write to an invalid address.

Function
REQ-018 SHALL raise a write event for one cycle when synchronised wr_n goes 1->0 while synchronised cs_n is 0; a held-low strobe SHALL produce exactly one event.
REQ-019 SHALL sample addr_i and data_i in the write-event cycle.
REQ-020 SHALL, for an event with addr < NUM_REGS, write data into shadow[addr] on the next edge; the active bank SHALL be unchanged.
REQ-021 SHALL treat addr == COMMIT_ADDR (all ones) as a commit command; data is ignored and the FSM goes IDLE->PENDING.
REQ-022 SHALL, for an event with NUM_REGS <= addr < COMMIT_ADDR, perform no write and set err_o until reset.
REQ-023 SHALL, in PENDING, copy the whole shadow bank into the active bank on the first cycle where run_i=0 or boundary_i=1, then return to IDLE.
REQ-024 SHALL assert cfg_update_o in the cycle after that copy, and SHALL deassert pending_o in the same cycle.
REQ-025 SHALL, on a commit while PENDING, stay PENDING with no extra update.
REQ-026 SHALL, when a shadow write and the apply happen in the same cycle, copy the old shadow value; the new value stays for the next commit.
REQ-027 SHALL update cfg_bus_o only at apply, with all registers changing in the same cycle.
REQ-028 SHALL have a latency from the wr_n_i pin falling to the shadow write of SYNC_STAGES+3 cycles.

Reset
REQ-029 SHALL, while rst_i=1, load shadow and active banks from RESET_VALUES, set FSM to IDLE, and hold pending_o, cfg_update_o and err_o at 0.
REQ-030 SHALL load the synchronisers to 1 (inactive), so no event fires on release.
REQ-031 SHALL, on reset during PENDING, drop the commit; no update pulse follows.

Configuration
REQ-032 SHALL, with FG_CFG_READBACK_EN defined, add output rd_data_o (DATA_W bits), driven from shadow[addr_i sampled on the cs_n falling edge] and registered one cycle later.
REQ-033 SHALL drive rd_data_o to 0 for an invalid address.
REQ-034 SHALL, without FG_CFG_READBACK_EN, have no rd_data_o port and no readback logic.

Structure
REQ-035 SHALL place in the shared package fg_cfg_pkg: the default RESET_VALUES constant, the COMMIT_ADDR function of ADDR_W, and the enum of FSM states IDLE/PENDING.
REQ-036 SHALL use one sub-module, fg_edge_sync: a parametrised synchroniser with reset value 1 plus a falling-edge detector, instantiated for wr_n_i and for cs_n_i.

Verification
REQ-037 SHALL check: reset -> cfg_bus_o=56'h49050000003200, pending_o=0, err_o=0.
REQ-038 SHALL check: with run_i=0, write addr 1 data 8'hA5 -> cfg_bus_o unchanged; then commit (addr 7) -> register 1 = 8'hA5 and one cfg_update_o pulse.
REQ-039 SHALL check: with run_i=1, write addr 5 = 8'h10, then commit -> pending_o=1 and bus unchanged until boundary_i; update one cycle after boundary_i.
REQ-040 SHALL check: wr_n_i held low for 20 cycles with data 8'h33 -> exactly one shadow write; a second commit while pending -> exactly one update pulse.
REQ-041 SHALL check: write addr 6 with NUM_REGS=6 -> err_o=1, no register changes; err_o stays 1 until rst_i.
REQ-042 SHALL check: rst_i asserted while pending -> bus returns to reset values, no cfg_update_o; with FG_CFG_READBACK_EN, read addr 1 after writing 8'h5A -> rd_data_o=8'h5A.
